pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_stage_mem.sv | 24 ++
 rtl/pipe_stage_buf.sv | 99 +++++++++
 tb/tb_pipe_stage_buf.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipe_stage_buf slice: default geometry and
// the statistics counter type with its saturating increment.
package pipe_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;
    localparam int STAT_W        = 32;

    typedef logic [STAT_W-1:0] stat_cnt_t;

    localparam stat_cnt_t STAT_MAX = '1;

    function automatic stat_cnt_t sat_inc(input stat_cnt_t v);
        return (v == STAT_MAX) ? v : v + stat_cnt_t'(1);
    endfunction
endpackage

// File: rtl/pipe_stage_mem.sv
// DEPTH x WIDTH storage for pipe_stage_buf: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module pipe_stage_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline buffer (FIFO of DEPTH entries) with synchronous flush.
// Define PIPE_STAGE_BUF_STATS_EN to add saturating stall/flush statistics outputs.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_STAGE_BUF_STATS_EN
    ,
    output stat_cnt_t                  stat_stall_cnt,
    output stat_cnt_t                  stat_flush_cnt
`endif
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH-1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    // Handshake: a beat transfers on a rising edge where valid && ready; ready
    // never depends on the same side's valid, and in_ready never sees out_ready.
    assign in_ready  = (occ < FULL_CNT) && !flush;
    assign out_valid = (occ != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? head : '0;
    assign count     = occ;

    pipe_stage_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

`ifdef PIPE_STAGE_BUF_STATS_EN
    // Flush cycles are counted only when they actually discard something.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_stall_cnt <= '0;
            stat_flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                stat_stall_cnt <= sat_inc(stat_stall_cnt);
            end
            if (flush && out_valid) begin
                stat_flush_cnt <= sat_inc(stat_flush_cnt);
            end
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a DEPTH=2 instance for basic/full/flush/reset
// cases and a DEPTH=3 instance for a wrapping stream checked against a queue.
module tb_pipe_stage_buf;
    logic        clk;
    logic        reset_n;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_count;

`ifdef PIPE_STAGE_BUF_STATS_EN
    logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q[$];

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2)) dut_a (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (a_flush),
        .in_valid       (a_in_valid),
        .in_ready       (a_in_ready),
        .in_data        (a_in_data),
        .out_valid      (a_out_valid),
        .out_ready      (a_out_ready),
        .out_data       (a_out_data),
        .count          (a_count)
`ifdef PIPE_STAGE_BUF_STATS_EN
        ,
        .stat_stall_cnt (a_stall_cnt),
        .stat_flush_cnt (a_flush_cnt)
`endif
    );

    pipe_stage_buf #(.WIDTH(32), .DEPTH(3)) dut_b (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (b_flush),
        .in_valid       (b_in_valid),
        .in_ready       (b_in_ready),
        .in_data        (b_in_data),
        .out_valid      (b_out_valid),
        .out_ready      (b_out_ready),
        .out_data       (b_out_data),
        .count          (b_count)
`ifdef PIPE_STAGE_BUF_STATS_EN
        ,
        .stat_stall_cnt (b_stall_cnt),
        .stat_flush_cnt (b_flush_cnt)
`endif
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int received;
        logic [31:0] exp_v;
        n_checks = 0;
        n_errors = 0;
        reset_n = 1'b0;
        a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
        check("rst_count", a_count, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_in_ready", a_in_ready, 1);
        tick();

        // single push with downstream always ready
        a_in_valid = 1; a_in_data = 32'hA5A5_0001; a_out_ready = 1;
        tick();
        a_in_valid = 0;
        check("one_valid", a_out_valid, 1);
        check("one_data", a_out_data, 32'hA5A5_0001);
        check("one_count", a_count, 1);
        tick();
        check("one_drain_count", a_count, 0);
        check("one_drain_valid", a_out_valid, 0);
        check("one_drain_data", a_out_data, 0);

        // fill to full, offer a third beat, then drain
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'h11;
        tick();
        check("fill1_count", a_count, 1);
        check("fill1_in_ready", a_in_ready, 1);
        check("fill1_data", a_out_data, 32'h11);
        a_in_data = 32'h22;
        tick();
        check("fill2_count", a_count, 2);
        check("fill2_in_ready", a_in_ready, 0);
        a_in_data = 32'h33;
        tick();
        check("full_hold_count", a_count, 2);
        check("full_hold_data", a_out_data, 32'h11);
        a_in_valid = 0; a_out_ready = 1;
        #1 check("drain_head", a_out_data, 32'h11);
        tick();
        check("drain_second", a_out_data, 32'h22);
        check("drain_count", a_count, 1);
        check("drain_in_ready", a_in_ready, 1);
        tick();
        check("drain_empty_count", a_count, 0);
        check("drain_empty_valid", a_out_valid, 0);
        a_out_ready = 0;

        // flush with a simultaneous push
        a_in_valid = 1; a_in_data = 32'h01;
        tick();
        a_in_data = 32'h02;
        tick();
        check("pre_flush_count", a_count, 2);
        a_flush = 1; a_in_data = 32'h99; a_out_ready = 1;
        #1 check("flush_in_ready", a_in_ready, 0);
        tick();
        a_flush = 0; a_in_valid = 0;
        check("flush_count", a_count, 0);
        check("flush_valid", a_out_valid, 0);
        check("flush_data", a_out_data, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_99", a_out_valid, 0);
        end
        a_out_ready = 0;

        // DEPTH=3 stream with toggling out_ready, checked against exp_q
        sent = 0;
        received = 0;
        for (int c = 0; c < 200 && received < 10; c++) begin
            b_in_valid  = (sent < 10);
            b_in_data   = 32'h100 + 32'(sent);
            b_out_ready = c[0];
            #1;
            check("stream_count", b_count, 64'(exp_q.size()));
            if (b_out_valid && b_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_spurious", b_out_valid, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("stream_data", b_out_data, exp_v);
                    received++;
                end
            end
            if (b_in_valid && b_in_ready) begin
                exp_q.push_back(b_in_data);
                sent++;
            end
            tick();
        end
        b_in_valid = 0; b_out_ready = 0;
        check("stream_received", received, 10);

        // asynchronous reset between clock edges
        a_in_valid = 1; a_in_data = 32'h77;
        tick();
        a_in_data = 32'h78;
        tick();
        a_in_valid = 0;
        check("pre_rst_count", a_count, 2);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_count", a_count, 0);
        check("async_rst_valid", a_out_valid, 0);
        check("async_rst_data", a_out_data, 0);
        #3 reset_n = 1'b1;
        #1 check("post_rst_in_ready", a_in_ready, 1);
        tick();

`ifdef PIPE_STAGE_BUF_STATS_EN
        // five stalled cycles, then one effective flush
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'h55;
        tick();
        a_in_valid = 0;
        repeat (5) tick();
        a_flush = 1; a_out_ready = 1;
        tick();
        a_flush = 0; a_out_ready = 0;
        check("stat_stall", a_stall_cnt, 5);
        check("stat_flush", a_flush_cnt, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
